hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage integer pipeline.
- Keeps a shadow copy of destination-register info for the EX, MEM and WB stages.
- Produces the registered 2-bit operand-select codes for the EX-stage operand muxes: 00 = ID/EX register data, 01 = MEM/WB result, 10 = EX/MEM result.
- Generates load-use stall/bubble control and freezes on data-memory busy.

Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_i  in  REG_AW  ID source register A
- id_rt_i  in  REG_AW  ID source register B
- id_use_rs_i  in  1  instruction reads rs
- id_use_rt_i  in  1  instruction reads rt
- id_rd_i  in  REG_AW  ID destination register
- id_regwrite_i  in  1  instruction writes the register file
- id_memread_i  in  1  instruction is a load
- flush_i  in  1  squash the ID instruction (taken branch/jump)
- mem_busy_i  in  1  data memory not ready; freeze the pipeline
- fwA_o  out  2  operand-A select for the instruction now in EX
- fwB_o  out  2  operand-B select for the instruction now in EX
- stall_o  out  1  hold PC and IF/ID (combinational)
- bubble_o  out  1  load ID/EX with a NOP this edge (combinational)
- state_o  out  2  00 RUN, 01 LU_STALL, 10 MEM_WAIT (registered)
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Shadow entries EX, MEM, WB each hold {valid, rd, regwrite, memread}.
- Reset (rst_i=0, asynchronous):
  - all shadow valid = 0
  - fwA_o = fwB_o = 00
  - state_o = RUN
  - stall_cnt_o = 0
- Load-use hazard, lu:
  - Condition: id_valid_i & EX.valid & EX.memread & EX.regwrite & EX.rd != 0 & ((id_use_rs_i & id_rs_i == EX.rd) | (id_use_rt_i & id_rt_i == EX.rd)) & !flush_i.
- stall_o = mem_busy_i | lu.
- bubble_o = lu & !mem_busy_i.
- Priority at each rising edge: mem_busy_i, then flush_i, then lu, then normal advance.
- MEM_WAIT (mem_busy_i = 1):
  - shadow entries, fwA_o, fwB_o all hold.
  - state_o <= MEM_WAIT.
- Flush (flush_i = 1, not busy):
  - WB <= MEM, MEM <= EX, EX <= invalid.
  - fwA_o = fwB_o <= 00.
  - state_o <= RUN.
- Load-use (lu = 1, not busy):
  - WB <= MEM, MEM <= EX, EX <= invalid (bubble).
  - fw outputs <= 00.
  - state_o <= LU_STALL.
  - The ID instruction re-presents next cycle. The load is then in MEM, so lu clears and forwarding selects 01. Each load-use hazard costs exactly one stall cycle.
- Normal advance:
  - WB <= MEM, MEM <= EX.
  - EX <= {id_valid_i, id_rd_i, id_regwrite_i & id_valid_i, id_memread_i & id_valid_i}.
  - state_o <= RUN.
- Forward select for each used source s (computed from pre-edge shadow, registered on advance):
  - 10 if EX.valid & EX.regwrite & EX.rd != 0 & EX.rd == s
  - else 01 if MEM.valid & MEM.regwrite & MEM.rd != 0 & MEM.rd == s
  - else 00
  - Unused source (use bit 0) or id_valid_i = 0 gives 00.
  - A match in both EX and MEM selects 10 (youngest value).
- WB-stage matches never forward: the register file is write-before-read.
- Register 0 never forwards and never causes a stall.
- Codes 11 are never produced.
- stall_cnt_o increments at each edge where stall_o = 1; it saturates at 2^CNT_W-1.
- Reset asserted mid-stall: all state clears immediately. stall_o then follows mem_busy_i only.

Test Plan:
- Back-to-back dependency: add r3 in ID, next cycle sub r5=r3+r4 in ID → fwA_o = 10 after the second advance edge, fwB_o = 00, stall_o never asserted.
- Distance-2 and double match: r3 written by I1 and I2, consumer I3 reads rs = r3 → fwA_o = 10. Repeat with only I1 writing r3 → fwA_o = 01.
- Load-use: lw r2, then add reading rt = r2 → stall_o = bubble_o = 1 for exactly one cycle, state_o = 01. Next advance gives fwB_o = 01 and stall_cnt_o = 1.
- Load-use with flush_i = 1 in the same cycle → stall_o = 0, EX shadow invalid, fw = 00, state_o = RUN.
- mem_busy_i high for 3 cycles during the load-use case → stall_o = 1 and bubble_o = 0 throughout, fw outputs hold, state_o = 10. The stall resolves after release, and stall_cnt_o = 4.
- Register 0: lw r0, consumer reads r0 → no stall, fw = 00. Assert rst_i = 0 during the MEM_WAIT state → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and hazard controller for the 5-stage integer pipeline.
// Tracks destination-register info for EX/MEM/WB, registers the EX operand-select
// codes, and raises load-use stall/bubble and memory-busy freeze.
module hazard_fwd_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  output logic [1:0]        fwA_o,
  output logic [1:0]        fwB_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } shadow_t;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLuStall = 2'b01,
    StMemWait = 2'b10
  } state_e;

  shadow_t          ex_q, mem_q, wb_q;
  shadow_t          ex_new;
  logic [1:0]       fw_a_q, fw_b_q, fw_a_d, fw_b_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             lu;
  logic             ex_load;

  // WB copy is kept for completeness; WB results reach EX via the register file.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  // Operand select: EX/MEM result wins over MEM/WB; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                         input shadow_t ex, input shadow_t mem);
    if (!used) return 2'b00;
    if (ex.valid && ex.regwrite && (ex.rd != '0) && (ex.rd == src)) return 2'b10;
    if (mem.valid && mem.regwrite && (mem.rd != '0) && (mem.rd == src)) return 2'b01;
    return 2'b00;
  endfunction

  // Load-use hazard detection and combinational stall/bubble outputs
  always_comb begin
    ex_load  = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != '0);
    lu       = id_valid_i && ex_load && !flush_i &&
               ((id_use_rs_i && (id_rs_i == ex_q.rd)) || (id_use_rt_i && (id_rt_i == ex_q.rd)));
    stall_o  = mem_busy_i || lu;
    bubble_o = lu && !mem_busy_i;
  end

  // Next forward codes and next EX shadow entry from the ID instruction
  always_comb begin
    fw_a_d          = fwd_sel(id_valid_i && id_use_rs_i, id_rs_i, ex_q, mem_q);
    fw_b_d          = fwd_sel(id_valid_i && id_use_rt_i, id_rt_i, ex_q, mem_q);
    ex_new.valid    = id_valid_i;
    ex_new.rd       = id_rd_i;
    ex_new.regwrite = id_regwrite_i && id_valid_i;
    ex_new.memread  = id_memread_i && id_valid_i;
  end

  // Shadow pipeline and registered forward codes: busy holds, flush/lu insert a bubble
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      fw_a_q <= 2'b00;
      fw_b_q <= 2'b00;
    end else if (mem_busy_i) begin
      ex_q   <= ex_q;
      mem_q  <= mem_q;
      wb_q   <= wb_q;
      fw_a_q <= fw_a_q;
      fw_b_q <= fw_b_q;
    end else if (flush_i || lu) begin
      wb_q   <= mem_q;
      mem_q  <= ex_q;
      ex_q   <= '0;
      fw_a_q <= 2'b00;
      fw_b_q <= 2'b00;
    end else begin
      wb_q   <= mem_q;
      mem_q  <= ex_q;
      ex_q   <= ex_new;
      fw_a_q <= fw_a_d;
      fw_b_q <= fw_b_d;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= StRun;
    else        state_q <= state_d;
  end

  // Next-state: same priority as the shadow update
  always_comb begin
    state_d = StRun;
    if (mem_busy_i)   state_d = StMemWait;
    else if (flush_i) state_d = StRun;
    else if (lu)      state_d = StLuStall;
  end

  // Outputs driven from registered state
  always_comb begin
    state_o = state_q;
    fwA_o   = fw_a_q;
    fwB_o   = fw_b_q;
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
